// File: rtl/freq_m_pkg.sv
// Shared definitions for the frequency meter: default counter width and count type.
package freq_m_pkg;

  localparam int unsigned CNT_WIDTH = 32;

  typedef logic [CNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/counter_32b.sv
// Binary up-counter with async clear, sync clear/load, count enable and
// combinational carry-out flagging the cycle before wrap.
module counter_32b
  import freq_m_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_WIDTH,
  parameter logic [63:0] MODULUS = 64'd0
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             sclr,
  input  logic             sload,
  input  logic [WIDTH-1:0] data,
  input  logic             cnt_en,
  output logic [WIDTH-1:0] q,
  output logic             cout
);

  localparam logic [WIDTH-1:0] TOP = (MODULUS == 64'd0) ? '1 : WIDTH'(MODULUS - 64'd1);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("counter_32b: WIDTH must be in 2..64");
  end

  if (MODULUS != 64'd0 &&
      (MODULUS < 64'd2 || (WIDTH < 64 && MODULUS >= (64'd1 << WIDTH)))) begin : g_bad_modulus
    $error("counter_32b: MODULUS must be 0 or in 2..2^WIDTH-1");
  end

  logic [WIDTH-1:0] r_q;
  logic             w_at_top;
  logic [WIDTH-1:0] w_load_val;

  assign w_at_top = (r_q == TOP);

  // Out-of-range loads collapse to 0; with full range nothing exceeds TOP.
  assign w_load_val = (data > TOP) ? '0 : data;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_q <= '0;
    end else if (sclr) begin
      r_q <= '0;
    end else if (sload) begin
      r_q <= w_load_val;
    end else if (cnt_en) begin
      if (w_at_top) begin
        r_q <= '0;
      end else begin
        r_q <= r_q + WIDTH'(1);
      end
    end
  end

  assign q    = r_q;
  assign cout = cnt_en & w_at_top;

endmodule

// File: tb/tb_counter_32b.sv
// Directed bench for counter_32b with an arithmetic reference model.
module tb_counter_32b;
  import freq_m_pkg::*;

  logic        clk = 1'b0;
  logic        rclk = 1'b0;
  logic        aclr_n, sclr, sload, cnt_en;
  logic [31:0] data;
  logic [31:0] q32;
  logic        cout32;
  logic [7:0]  q10;
  logic        cout10;

  logic        gate;
  count_t      q_ref, q_meas;
  logic        cout_ref, cout_meas;

  int n_vec = 0;
  int n_err = 0;

  longint unsigned m32, m10;

  always #5  clk  = ~clk;
  always #15 rclk = ~rclk;

  counter_32b #(.WIDTH(32), .MODULUS(64'd0)) u_full (
    .clock(clk), .aclr_n(aclr_n), .sclr(sclr), .sload(sload),
    .data(data), .cnt_en(cnt_en), .q(q32), .cout(cout32)
  );

  counter_32b #(.WIDTH(8), .MODULUS(64'd10)) u_mod10 (
    .clock(clk), .aclr_n(aclr_n), .sclr(sclr), .sload(sload),
    .data(data[7:0]), .cnt_en(cnt_en), .q(q10), .cout(cout10)
  );

  counter_32b #(.WIDTH(CNT_WIDTH), .MODULUS(64'd0)) u_ref (
    .clock(rclk), .aclr_n(aclr_n), .sclr(1'b0), .sload(1'b0),
    .data('0), .cnt_en(gate), .q(q_ref), .cout(cout_ref)
  );

  counter_32b #(.WIDTH(CNT_WIDTH), .MODULUS(64'd0)) u_meas (
    .clock(clk), .aclr_n(aclr_n), .sclr(1'b0), .sload(1'b0),
    .data('0), .cnt_en(gate), .q(q_meas), .cout(cout_meas)
  );

  // Reference model: count modulo M, loads above M-1 become 0.
  function automatic longint unsigned next_val(longint unsigned cur, longint unsigned m,
                                               longint unsigned d, logic c, logic l, logic e);
    if (c) return 0;
    if (l) return (d >= m) ? 0 : d;
    if (e) return (cur + 1) % m;
    return cur;
  endfunction

  always @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      m32 <= 0;
      m10 <= 0;
    end else begin
      m32 <= next_val(m32, 64'h1_0000_0000, longint'(data), sclr, sload, cnt_en);
      m10 <= next_val(m10, 64'd10, longint'(data[7:0]), sclr, sload, cnt_en);
    end
  end

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model q32", longint'(q32), m32);
    chk("model cout32", longint'(cout32), longint'(cnt_en && m32 == 64'hFFFF_FFFF));
    chk("model q10", longint'(q10), m10);
    chk("model cout10", longint'(cout10), longint'(cnt_en && m10 == 64'd9));
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    aclr_n = 1'b0; sclr = 1'b0; sload = 1'b0; cnt_en = 1'b0; data = '0; gate = 1'b0;
    tick(2);
    chk("reset q", longint'(q32), 0);
    chk("reset cout", longint'(cout32), 0);
    aclr_n = 1'b1;

    // async clear mid-count
    sload = 1'b1; data = 32'd37;
    tick(1);
    sload = 1'b0;
    chk("load 37", longint'(q32), 37);
    chk("load 37 clipped mod10", longint'(q10), 0);
    aclr_n = 1'b0;
    #1;
    chk("aclr immediate q", longint'(q32), 0);
    chk("aclr cout", longint'(cout32), 0);
    tick(1);
    aclr_n = 1'b1;
    cnt_en = 1'b1;
    tick(5);
    chk("count after release", longint'(q32), 5);

    // full-range wrap
    sload = 1'b1; data = 32'hFFFF_FFFE;
    tick(1);
    sload = 1'b0;
    chk("load FFFFFFFE", longint'(q32), 64'hFFFF_FFFE);
    tick(1);
    chk("at top q", longint'(q32), 64'hFFFF_FFFF);
    chk("at top cout", longint'(cout32), 1);
    tick(1);
    chk("wrap q", longint'(q32), 0);
    chk("wrap cout", longint'(cout32), 0);

    // modulus 10 sequence
    sclr = 1'b1;
    tick(1);
    sclr = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      chk("mod10 q", longint'(q10), longint'(i % 10));
      chk("mod10 cout", longint'(cout10), longint'(i == 9));
      tick(1);
    end

    // priority
    sload = 1'b1; data = 32'd7;
    tick(1);
    chk("load 7", longint'(q32), 7);
    sclr = 1'b1; sload = 1'b1; data = 32'd100; cnt_en = 1'b1;
    tick(1);
    chk("sclr wins", longint'(q32), 0);
    sclr = 1'b0;
    tick(1);
    chk("sload over cnt_en", longint'(q32), 100);
    chk("mod10 load 100 clipped", longint'(q10), 0);

    // enable hold
    data = 32'd12;
    tick(1);
    sload = 1'b0; cnt_en = 1'b0;
    tick(4);
    chk("hold 12", longint'(q32), 12);
    sload = 1'b1; data = 32'hFFFF_FFFF;
    tick(1);
    sload = 1'b0;
    chk("top no en cout", longint'(cout32), 0);
    tick(2);
    chk("hold top", longint'(q32), 64'hFFFF_FFFF);

    // gate measurement: 1000 ref cycles, meas clock 3x faster
    @(posedge rclk); #7;
    gate = 1'b1;
    repeat (1000) @(posedge rclk);
    #7;
    gate = 1'b0;
    #40;
    chk("gate ref count", longint'(q_ref), 1000);
    n_vec++;
    if (q_meas < 32'd2999 || q_meas > 32'd3001) begin
      n_err++;
      $display("FAIL gate meas count: got %0d expected 3000 +/-1", q_meas);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
